// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler: rotates three SDRAM frame banks between writer, ready slot and display.
// Optional macro FB_FREEZE_EN adds iFREEZE, which holds the displayed bank while capture continues.
module frame_bank_scheduler #(
  parameter int                ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 22'h000000,
  parameter logic [ADDR_W-1:0] BANK_STRIDE = 22'h050000,
  parameter int                FRAME_WORDS = 640*480,
  parameter int                CNT_W       = 16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSTART,
  input  logic              iEND,
  input  logic              iWR_FRAME_START,
  input  logic              iWR_FRAME_DONE,
  input  logic              iRD_FRAME_START,
`ifdef FB_FREEZE_EN
  input  logic              iFREEZE,
`endif
  output logic              oCAPTURE_EN,
  output logic [ADDR_W-1:0] oWR_BASE,
  output logic [ADDR_W-1:0] oWR_MAX,
  output logic [ADDR_W-1:0] oRD_BASE,
  output logic [ADDR_W-1:0] oRD_MAX,
  output logic              oWR_LOAD,
  output logic              oRD_LOAD,
  output logic [1:0]        oWR_BANK,
  output logic [1:0]        oRD_BANK,
  output logic [CNT_W-1:0]  oFRAME_CNT,
  output logic [CNT_W-1:0]  oDROP_CNT
);

  localparam logic [1:0] ST_STOP     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_WRITING  = 2'd2;
  localparam logic [1:0] ST_STOPPING = 2'd3;

  localparam logic [ADDR_W-1:0] FRAME_SPAN = ADDR_W'(FRAME_WORDS);

  function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] bank);
    case (bank)
      2'd1:    return BASE_ADDR + BANK_STRIDE;
      2'd2:    return BASE_ADDR + BANK_STRIDE + BANK_STRIDE;
      default: return BASE_ADDR;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic [1:0]       w_q, w_d, r_q, r_d, d_q, d_d;
  logic             rv_q, rv_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic             wr_load_q, wr_load_d, rd_load_q, rd_load_d;

  logic       commit, abort, restart, swap_ok, freeze, start_ok;
  logic [1:0] w_mid, r_mid;
  logic       rv_mid;

`ifdef FB_FREEZE_EN
  assign freeze = iFREEZE;
`else
  assign freeze = 1'b0;
`endif

  // iEND beats a simultaneous iSTART everywhere it matters
  assign start_ok = iSTART && !iEND;

  always_comb begin
    state_d     = state_q;
    commit      = 1'b0;
    abort       = 1'b0;
    restart     = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (start_ok) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (iEND) begin
          state_d = ST_STOP;
        end else if (iWR_FRAME_START) begin
          state_d = ST_WRITING;
          restart = 1'b1;
        end
      end
      ST_WRITING: begin
        if (iWR_FRAME_DONE) begin
          commit  = 1'b1;
          state_d = iEND ? ST_STOP : ST_ARMED;
        end else if (iWR_FRAME_START) begin
          abort   = 1'b1;
          state_d = iEND ? ST_STOPPING : ST_WRITING;
        end else if (iEND) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (iWR_FRAME_DONE) begin
          commit  = 1'b1;
          state_d = start_ok ? ST_ARMED : ST_STOP;
        end else if (iWR_FRAME_START) begin
          abort   = 1'b1;
          state_d = start_ok ? ST_WRITING : ST_STOPPING;
        end else if (start_ok) begin
          state_d = ST_WRITING;
        end
      end
      default: state_d = ST_STOP;
    endcase

    // Commit is applied first so a same-cycle display swap picks up the fresh frame
    w_mid       = w_q;
    r_mid       = r_q;
    rv_mid      = rv_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (commit) begin
      w_mid       = r_q;
      r_mid       = w_q;
      rv_mid      = 1'b1;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
    if (abort) drop_cnt_d = drop_cnt_q + CNT_W'(1);

    swap_ok = iRD_FRAME_START && rv_mid && !freeze;
    w_d     = w_mid;
    if (swap_ok) begin
      d_d  = r_mid;
      r_d  = d_q;
      rv_d = 1'b0;
    end else begin
      d_d  = d_q;
      r_d  = r_mid;
      rv_d = rv_mid;
    end

    wr_req_d  = commit || abort || restart;
    rd_req_d  = swap_ok;
    wr_load_d = wr_req_q;
    rd_load_d = rd_req_q;
  end

  // Reset leaves both load requests pending so the first cycle after release reloads both ports
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q     <= ST_STOP;
      w_q         <= 2'd0;
      r_q         <= 2'd1;
      d_q         <= 2'd2;
      rv_q        <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      wr_req_q    <= 1'b1;
      rd_req_q    <= 1'b1;
      wr_load_q   <= 1'b0;
      rd_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      r_q         <= r_d;
      d_q         <= d_d;
      rv_q        <= rv_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      wr_load_q   <= wr_load_d;
      rd_load_q   <= rd_load_d;
    end
  end

  assign oCAPTURE_EN = (state_q == ST_WRITING) || (state_q == ST_STOPPING);
  assign oWR_BANK    = w_q;
  assign oRD_BANK    = d_q;
  assign oWR_BASE    = bank_base(w_q);
  assign oWR_MAX     = bank_base(w_q) + FRAME_SPAN;
  assign oRD_BASE    = bank_base(d_q);
  assign oRD_MAX     = bank_base(d_q) + FRAME_SPAN;
  assign oWR_LOAD    = wr_load_q;
  assign oRD_LOAD    = rd_load_q;
  assign oFRAME_CNT  = frame_cnt_q;
  assign oDROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Scoreboard bench for frame_bank_scheduler: every LOAD strobe is matched against a queued expectation.
module tb_frame_bank_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_end, i_fs, i_fd, i_rs;
`ifdef FB_FREEZE_EN
  logic        i_freeze;
`endif
  logic        cap_en;
  logic [21:0] wr_base, wr_max, rd_base, rd_max;
  logic        wr_load, rd_load;
  logic [1:0]  wr_bank, rd_bank;
  logic [15:0] frame_cnt, drop_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wl, rl;
    logic [1:0]  wb, rb;
    logic [21:0] wbase, rbase, rmax;
    logic [15:0] fc, dc;
  } exp_t;

  exp_t exp_q[$];

  frame_bank_scheduler dut (
    .iCLK            (clk),
    .iRST_N          (rst_n),
    .iSTART          (i_start),
    .iEND            (i_end),
    .iWR_FRAME_START (i_fs),
    .iWR_FRAME_DONE  (i_fd),
    .iRD_FRAME_START (i_rs),
`ifdef FB_FREEZE_EN
    .iFREEZE         (i_freeze),
`endif
    .oCAPTURE_EN     (cap_en),
    .oWR_BASE        (wr_base),
    .oWR_MAX         (wr_max),
    .oRD_BASE        (rd_base),
    .oRD_MAX         (rd_max),
    .oWR_LOAD        (wr_load),
    .oRD_LOAD        (rd_load),
    .oWR_BANK        (wr_bank),
    .oRD_BANK        (rd_bank),
    .oFRAME_CNT      (frame_cnt),
    .oDROP_CNT       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic wl, input logic rl, input logic [1:0] wb, input logic [1:0] rb,
                      input logic [21:0] wbase, input logic [21:0] rbase, input logic [21:0] rmax,
                      input logic [15:0] fc, input logic [15:0] dc);
    exp_t e;
    e.wl = wl; e.rl = rl; e.wb = wb; e.rb = rb;
    e.wbase = wbase; e.rbase = rbase; e.rmax = rmax; e.fc = fc; e.dc = dc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic e, input logic fs, input logic fd, input logic rs);
    i_start = s; i_end = e; i_fs = fs; i_fd = fd; i_rs = rs;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_end = 1'b0; i_fs = 1'b0; i_fd = 1'b0; i_rs = 1'b0;
  endtask

  // Monitor: any LOAD strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (wr_load || rd_load)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load wr_load=%0d rd_load=%0d required none", wr_load, rd_load);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_load", 32'(wr_load), 32'(e.wl));
        chk("rd_load", 32'(rd_load), 32'(e.rl));
        chk("wr_bank", 32'(wr_bank), 32'(e.wb));
        chk("rd_bank", 32'(rd_bank), 32'(e.rb));
        chk("wr_base", 32'(wr_base), 32'(e.wbase));
        chk("rd_base", 32'(rd_base), 32'(e.rbase));
        chk("rd_max", 32'(rd_max), 32'(e.rmax));
        chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        chk("drop_cnt", 32'(drop_cnt), 32'(e.dc));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0; i_end = 1'b0; i_fs = 1'b0; i_fd = 1'b0; i_rs = 1'b0;
`ifdef FB_FREEZE_EN
    i_freeze = 1'b0;
`endif
    idle(3);
    @(negedge clk);
    chk("rst_wr_bank", 32'(wr_bank), 32'd0);
    chk("rst_rd_bank", 32'(rd_bank), 32'd2);
    chk("rst_wr_base", 32'(wr_base), 32'h000000);
    chk("rst_wr_max", 32'(wr_max), 32'h04B000);
    chk("rst_rd_base", 32'(rd_base), 32'h0A0000);
    chk("rst_loads", 32'({wr_load, rd_load}), 32'd0);
    chk("rst_cap_en", 32'(cap_en), 32'd0);
    chk("rst_counters", 32'({frame_cnt, drop_cnt}), 32'd0);

    // Release: both ports reload once
    push(1, 1, 2'd0, 2'd2, 22'h000000, 22'h0A0000, 22'h0EB000, 16'd0, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // Start, write one frame, commit, then display swap
    pulse(1, 0, 0, 0, 0); idle(2);
    push(1, 0, 2'd0, 2'd2, 22'h000000, 22'h0A0000, 22'h0EB000, 16'd0, 16'd0);
    pulse(0, 0, 1, 0, 0); idle(3);
    chk("cap_en_writing", 32'(cap_en), 32'd1);
    push(1, 0, 2'd1, 2'd2, 22'h050000, 22'h0A0000, 22'h0EB000, 16'd1, 16'd0);
    pulse(0, 0, 0, 1, 0); idle(3);
    chk("cap_en_armed", 32'(cap_en), 32'd0);
    push(0, 1, 2'd1, 2'd0, 22'h050000, 22'h000000, 22'h04B000, 16'd1, 16'd0);
    pulse(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("rd_bank_before_load", 32'(rd_bank), 32'd0);
    chk("rd_load_lags_update", 32'(rd_load), 32'd0);
    idle(3);

    // Commit and display swap in one cycle (W1 R2 D0 -> W2 D1 R0)
    push(1, 0, 2'd1, 2'd0, 22'h050000, 22'h000000, 22'h04B000, 16'd1, 16'd0);
    pulse(0, 0, 1, 0, 0); idle(3);
    push(1, 1, 2'd2, 2'd1, 22'h0A0000, 22'h050000, 22'h09B000, 16'd2, 16'd0);
    pulse(0, 0, 0, 1, 1); idle(3);
    pulse(0, 0, 0, 0, 1); idle(3);

    // Abort: second frame start without done
    push(1, 0, 2'd2, 2'd1, 22'h0A0000, 22'h050000, 22'h09B000, 16'd2, 16'd0);
    pulse(0, 0, 1, 0, 0); idle(3);
    push(1, 0, 2'd2, 2'd1, 22'h0A0000, 22'h050000, 22'h09B000, 16'd2, 16'd1);
    pulse(0, 0, 1, 0, 0); idle(3);

    // Snapshot: iEND while writing, then done commits and stops
    pulse(0, 1, 0, 0, 0); idle(2);
    chk("cap_en_stopping", 32'(cap_en), 32'd1);
    push(1, 0, 2'd0, 2'd1, 22'h000000, 22'h050000, 22'h09B000, 16'd3, 16'd1);
    pulse(0, 0, 0, 1, 0); idle(3);
    chk("cap_en_stopped", 32'(cap_en), 32'd0);
    pulse(0, 0, 1, 0, 0); idle(3);
    chk("ignored_fs_bank", 32'(wr_bank), 32'd0);
    pulse(1, 1, 0, 0, 0); idle(2);
    pulse(0, 0, 1, 0, 0); idle(3);
    chk("end_beats_start", 32'(cap_en), 32'd0);
    push(0, 1, 2'd0, 2'd2, 22'h000000, 22'h0A0000, 22'h0EB000, 16'd3, 16'd1);
    pulse(0, 0, 0, 0, 1); idle(3);

    // Reset mid-frame
    pulse(1, 0, 0, 0, 0); idle(2);
    push(1, 0, 2'd0, 2'd2, 22'h000000, 22'h0A0000, 22'h0EB000, 16'd3, 16'd1);
    pulse(0, 0, 1, 0, 0); idle(3);
    push(1, 1, 2'd0, 2'd2, 22'h000000, 22'h0A0000, 22'h0EB000, 16'd0, 16'd0);
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    chk("midrst_cap_en", 32'(cap_en), 32'd0);
    chk("midrst_counters", 32'({frame_cnt, drop_cnt}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // Same-cycle commit and read start from reset banks (W0 R1 D2 -> W1 D0 R2)
    pulse(1, 0, 0, 0, 0); idle(2);
    push(1, 0, 2'd0, 2'd2, 22'h000000, 22'h0A0000, 22'h0EB000, 16'd0, 16'd0);
    pulse(0, 0, 1, 0, 0); idle(3);
    push(1, 1, 2'd1, 2'd0, 22'h050000, 22'h000000, 22'h04B000, 16'd1, 16'd0);
    pulse(0, 0, 0, 1, 1); idle(3);
    pulse(0, 0, 0, 0, 1); idle(3);
    chk("no_swap_rv0", 32'(rd_bank), 32'd0);

`ifdef FB_FREEZE_EN
    // Freeze across three commits and read starts, then release
    i_freeze = 1'b1;
    push(1, 0, 2'd1, 2'd0, 22'h050000, 22'h000000, 22'h04B000, 16'd1, 16'd0);
    pulse(0, 0, 1, 0, 0); idle(3);
    push(1, 0, 2'd2, 2'd0, 22'h0A0000, 22'h000000, 22'h04B000, 16'd2, 16'd0);
    pulse(0, 0, 0, 1, 0); idle(3);
    pulse(0, 0, 0, 0, 1); idle(3);
    push(1, 0, 2'd2, 2'd0, 22'h0A0000, 22'h000000, 22'h04B000, 16'd2, 16'd0);
    pulse(0, 0, 1, 0, 0); idle(3);
    push(1, 0, 2'd1, 2'd0, 22'h050000, 22'h000000, 22'h04B000, 16'd3, 16'd0);
    pulse(0, 0, 0, 1, 0); idle(3);
    pulse(0, 0, 0, 0, 1); idle(3);
    push(1, 0, 2'd1, 2'd0, 22'h050000, 22'h000000, 22'h04B000, 16'd3, 16'd0);
    pulse(0, 0, 1, 0, 0); idle(3);
    push(1, 0, 2'd2, 2'd0, 22'h0A0000, 22'h000000, 22'h04B000, 16'd4, 16'd0);
    pulse(0, 0, 0, 1, 0); idle(3);
    pulse(0, 0, 0, 0, 1); idle(3);
    chk("freeze_d_held", 32'(rd_bank), 32'd0);
    i_freeze = 1'b0;
    idle(1);
    push(0, 1, 2'd2, 2'd1, 22'h0A0000, 22'h050000, 22'h09B000, 16'd4, 16'd0);
    pulse(0, 0, 0, 0, 1); idle(3);
`endif

    idle(6);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_bank_scheduler.md
Name: frame_bank_scheduler

Overview:
- Triple-buffer scheduler for the SDRAM frame store between the CCD write path and the VGA read path.
- Assigns one of three frame banks each to writer, ready slot and display. Swaps roles at frame boundaries so the display never shows a partially written frame.
- Drives base/max addresses and one-cycle LOAD pulses into the 4-port SDRAM controller's WR/RD address inputs.
- Sequences capture start/stop (run / snapshot) for the capture path.

Parameters:
- ADDR_W, 22, SDRAM word address width.
- BASE_ADDR, 22'h000000, address of bank 0.
- BANK_STRIDE, 22'h050000, spacing between banks; must be >= FRAME_WORDS.
- FRAME_WORDS, 640*480, words per frame; max address = base + FRAME_WORDS.
- CNT_W, 16, width of the frame and drop counters.

Ports:
- iCLK  in  1  system clock (CLOCK_50 domain); all inputs synchronous to it.
- iRST_N  in  1  synchronous active-low reset.
- iSTART  in  1  pulse: start continuous capture.
- iEND  in  1  pulse: stop capture after the current frame (snapshot).
- iWR_FRAME_START  in  1  pulse: camera frame begins (FVAL rise, pre-synchronised).
- iWR_FRAME_DONE  in  1  pulse: last pixel of frame flushed to SDRAM.
- iRD_FRAME_START  in  1  pulse: VGA vertical blank start.
- oCAPTURE_EN  out  1  gate for capture data valid.
- oWR_BASE / oWR_MAX  out  ADDR_W  writer bank start / end.
- oRD_BASE / oRD_MAX  out  ADDR_W  display bank start / end.
- oWR_LOAD / oRD_LOAD  out  1  one-cycle address reload strobes.
- oWR_BANK / oRD_BANK  out  2  bank index 0..2.
- oFRAME_CNT  out  CNT_W  completed frames.
- oDROP_CNT  out  CNT_W  aborted frames.

Behaviour:
- Bank state: W, R, D always a permutation of {0,1,2}; ready_valid flag.
- Reset values: W=0, R=1, D=2, ready_valid=0, oCAPTURE_EN=0, counters=0, LOADs=0.
- Base addresses: bank n base = BASE_ADDR + n*BANK_STRIDE; MAX = base + FRAME_WORDS. Outputs are registered from W/D.
- First cycle after iRST_N goes high: oWR_LOAD=1 and oRD_LOAD=1 for exactly one cycle.
- Capture FSM states: STOP, ARMED, WRITING, STOPPING.
  - STOP: iSTART -> ARMED.
  - ARMED: iWR_FRAME_START -> WRITING, oWR_LOAD pulse; iEND -> STOP.
  - WRITING: iWR_FRAME_DONE -> commit, then ARMED; iEND -> STOPPING.
  - STOPPING: iWR_FRAME_DONE -> commit, then STOP. iSTART -> WRITING (cancels the stop).
  - oCAPTURE_EN=1 in WRITING and STOPPING only.
  - iSTART and iEND in the same cycle: iEND wins.
- Abort: iWR_FRAME_START while WRITING or STOPPING:
  - no commit; oDROP_CNT+1 (wraps);
  - restart the same bank with a new oWR_LOAD;
  - state becomes WRITING, or stays STOPPING.
- iWR_FRAME_DONE in STOP or ARMED: ignored.
- Commit: swap W<->R; ready_valid=1; oFRAME_CNT+1 (wraps at 2^CNT_W).
- Display swap: iRD_FRAME_START with ready_valid=1: swap D<->R, ready_valid=0. With ready_valid=0: D unchanged, no oRD_LOAD.
- Simultaneous commit and display swap in the same cycle: apply commit first, then display swap. Result: W'=oldR, D'=oldW, R'=oldD, ready_valid=0.
- Load timing: W/D registers update at edge N; base/max outputs valid from N; the LOAD strobe is asserted in cycle N+1.
- Reset asserted mid-frame: all state returns to reset values on the next edge; counters clear.

Optional Feature:
- Macro FB_FREEZE_EN.
- Defined: adds input iFREEZE (1 bit). While iFREEZE=1, display swaps are suppressed (D held, ready_valid kept). Commits continue, so R always holds the newest frame. The first iRD_FRAME_START after iFREEZE falls swaps normally.
- Undefined: no port; display swaps always allowed.

Test Plan:
- Reset release -> W=0, D=2, oWR_BASE=0x000000, oRD_BASE=0x0A0000; oWR_LOAD and oRD_LOAD high for exactly 1 cycle; counters 0.
- iSTART, iWR_FRAME_START, iWR_FRAME_DONE, then iRD_FRAME_START -> oFRAME_CNT=1, W=1, R=0; after the read start D=0, oRD_BASE=0x000000, oRD_MAX=0x04B000, oRD_LOAD 1 cycle after the update.
- Commit and iRD_FRAME_START in the same cycle from W=0, R=1, D=2 with ready_valid=0 -> W=1, D=0, R=2, ready_valid=0.
- Two iWR_FRAME_START with no done in between -> oDROP_CNT=1, W unchanged, second oWR_LOAD seen, oFRAME_CNT unchanged.
- iEND during WRITING, then iWR_FRAME_DONE -> frame committed, FSM in STOP, oCAPTURE_EN=0; a later iWR_FRAME_START is ignored.
- FB_FREEZE_EN defined, iFREEZE=1 over 3 commits and 3 read starts -> D unchanged; iFREEZE=0 then next read start -> D = last committed bank.
